// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the MIPS datapath.
// Executes single-cycle logic/arithmetic ops, bit-serial shifts and a
// shift-add multiply behind a start/busy/done handshake. Result and flags
// are registered and held between done pulses.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start                request, sampled only in IDLE
//   control[3:0]         opcode (0 MOVE,1 ADD,2 AND,3 NOT,4 NOR,5 SUB,
//                        6 SLL,7 SRL,8 SRA,9 MUL, 10-15 illegal)
//   input0, input1       operands (input1 low bits give the shift amount)
//   busy                 operation in progress (excludes the done cycle)
//   done                 one-cycle completion pulse
//   result               registered result
//   zero, negative       result == 0, result MSB
//   carry, overflow      op-specific carry, signed overflow (ADD/SUB)
//   illegal              last completed opcode was undefined
module seq_alu #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             illegal
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_MOVE = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [3:0]         op_q;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [SHAMT_W-1:0] n;
    assign n = input1[SHAMT_W-1:0];

    // Single-cycle evaluation straight from the operand inputs.
    logic [WIDTH:0]   sum_x, dif_x;
    logic [WIDTH-1:0] s_res;
    logic             s_c, s_v, s_ill, s_multi;

    always_comb begin
        sum_x   = {1'b0, input0} + {1'b0, input1};
        dif_x   = {1'b0, input0} - {1'b0, input1};
        s_res   = '0;
        s_c     = 1'b0;
        s_v     = 1'b0;
        s_ill   = 1'b0;
        s_multi = 1'b0;
        case (control)
            OP_MOVE: s_res = input0;
            OP_ADD: begin
                s_res = sum_x[WIDTH-1:0];
                s_c   = sum_x[WIDTH];
                s_v   = (input0[WIDTH-1] == input1[WIDTH-1]) &&
                        (sum_x[WIDTH-1] != input0[WIDTH-1]);
            end
            OP_AND:  s_res = input0 & input1;
            OP_NOT:  s_res = ~input0;
            OP_NOR:  s_res = ~(input0 | input1);
            OP_SUB: begin
                s_res = dif_x[WIDTH-1:0];
                s_c   = ~dif_x[WIDTH];          // no borrow
                s_v   = (input0[WIDTH-1] != input1[WIDTH-1]) &&
                        (dif_x[WIDTH-1] != input0[WIDTH-1]);
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                s_res   = input0;               // used only when n == 0
                s_multi = (n != '0);
            end
            OP_MUL:  s_multi = 1'b1;
            default: s_ill = 1'b1;
        endcase
    end

    // One iteration of the serial shift / shift-add multiply.
    logic [WIDTH-1:0]   w_next;
    logic               w_out;
    logic [WIDTH:0]     part;
    logic [2*WIDTH-1:0] acc_next;
    logic               last;

    always_comb begin
        w_next = work;
        w_out  = 1'b0;
        case (op_q)
            OP_SLL: begin
                w_next = {work[WIDTH-2:0], 1'b0};
                w_out  = work[WIDTH-1];
            end
            OP_SRL: begin
                w_next = {1'b0, work[WIDTH-1:1]};
                w_out  = work[0];
            end
            default: begin
                w_next = {work[WIDTH-1], work[WIDTH-1:1]};
                w_out  = work[0];
            end
        endcase
        // acc = {partial product, remaining multiplier bits}; add the
        // multiplicand into the high half when the current bit is set, then
        // shift the whole accumulator right by one.
        part     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {part, acc[WIDTH-1:1]};
    end

    assign last = (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            op_q     <= '0;
            work     <= '0;
            mcand    <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            negative <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= control;
                        work  <= input0;
                        mcand <= input0;
                        acc   <= {{WIDTH{1'b0}}, input1};
                        if (s_multi) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= (control == OP_MUL) ? CNT_W'(WIDTH)
                                                         : CNT_W'(n);
                        end else begin
                            state    <= DONE;
                            done     <= 1'b1;
                            result   <= s_res;
                            zero     <= ~s_ill && (s_res == '0);
                            negative <= s_res[WIDTH-1];
                            carry    <= s_c;
                            overflow <= s_v;
                            illegal  <= s_ill;
                        end
                    end
                end
                RUN: begin
                    cnt  <= cnt - CNT_W'(1);
                    work <= w_next;
                    acc  <= acc_next;
                    // The final iteration writes its own result directly so
                    // done appears the cycle after the last shift.
                    if (last) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        overflow <= 1'b0;
                        illegal  <= 1'b0;
                        if (op_q == OP_MUL) begin
                            result   <= acc_next[WIDTH-1:0];
                            zero     <= (acc_next[WIDTH-1:0] == '0);
                            negative <= acc_next[WIDTH-1];
                            carry    <= |acc_next[2*WIDTH-1:WIDTH];
                        end else begin
                            result   <= w_next;
                            zero     <= (w_next == '0);
                            negative <= w_next[WIDTH-1];
                            carry    <= w_out;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU for the MIPS datapath. It executes single-cycle logic and arithmetic ops, barrel-free iterative shifts by a variable amount, and a shift-add multiply. Operands are captured on a start/busy/done handshake, and the result and flags are registered. It sits between the register file read ports and the writeback mux, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, default 8: datapath width in bits, ≥ 4.
- `SHAMT_W`, default `$clog2(WIDTH)`: width of the shift amount taken from `input1`.
- `clk` in, 1: single clock; all state updates on the rising edge.
- `reset_n` in, 1: asynchronous, active-low reset.
- `start` in, 1: request; sampled only in IDLE.
- `control` in, 4: operation code, captured at start.
- `input0` in, WIDTH: first operand, captured at start.
- `input1` in, WIDTH: second operand or shift amount, captured at start.
- `busy` out, 1: high from the cycle after an accepted start through the done cycle, exclusive.
- `done` out, 1: one-cycle pulse; the result and flags are valid and then held until the next done.
- `result` out, WIDTH: registered result.
- `zero` out, 1: `result == 0`.
- `negative` out, 1: `result[WIDTH-1]`.
- `carry` out, 1: op-specific, see below.
- `overflow` out, 1: signed overflow, ADD/SUB only.
- `illegal` out, 1: the last completed op code was undefined.

## Operation
- Opcodes:
  - 0 MOVE: `input0`.
  - 1 ADD.
  - 2 AND.
  - 3 NOT: `~input0`.
  - 4 NOR.
  - 5 SUB: `input0 - input1`.
  - 6 SLL, 7 SRL, 8 SRA: shift `input0` by `n = input1[SHAMT_W-1:0]`.
  - 9 MUL: low WIDTH bits of the unsigned product.
  - 10–15: illegal.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start=1` latches the operands and opcode.
  - Single-cycle ops, shifts with n=0, and illegal ops go directly to DONE.
  - Shifts with n>0 and MUL go to RUN.
- RUN, shifts:
  - One bit per cycle; a down-counter loads n and the state exits at count 0.
  - SRA replicates the MSB.
- RUN, MUL:
  - Shift-add over WIDTH iterations with a 2·WIDTH accumulator.
- DONE:
  - `done=1` for one cycle, and the result and flags are written in this cycle.
  - Next state is IDLE.
  - A `start` present during DONE is ignored; it must be reasserted in IDLE.
- `start` while `busy` is ignored, and the latched operands are unaffected by input changes.
- Flags:
  - `zero` and `negative` are derived from the final result for every legal op.
  - `carry`, per op:
    - ADD: carry-out.
    - SUB: 1 when there is no borrow (`input0 ≥ input1` unsigned).
    - Shifts: the last bit shifted out, 0 when n=0.
    - MUL: 1 if the product's high half is nonzero.
    - All other ops: 0.
  - `overflow`: two's-complement overflow for ADD/SUB, 0 otherwise.
- Illegal op: `result=0`, all flags 0 (including `zero`), `illegal=1`. Any legal completion clears `illegal`.
- All arithmetic is modulo 2^WIDTH. The shift amount is always less than WIDTH by construction.

## Timing
- Reset (async, mid-operation included):
  - State goes to IDLE.
  - `busy`, `done`, `result`, `zero`, `negative`, `carry`, `overflow` and `illegal` all go to 0.
  - In-flight work is discarded. The first start is accepted on the first rising edge with `reset_n=1`.
- Start is accepted at edge k.
- Latency:
  - Single-cycle, n=0 and illegal ops: `done` in cycle k+1.
  - Shifts with n>0: `done` in cycle k+n+1.
  - MUL: `done` in cycle k+WIDTH+1.
- `busy` is high over cycles k+1 … done−1 and is low in the done cycle, which is an accepted-start edge only if this is IDLE.
- Minimum initiation interval is 2 cycles (done, then IDLE).
- Outputs hold their values between done pulses and never glitch on operand changes.

## Test plan
- Reset, then ADD 8'h7F+8'h01 → `done` at k+1, `result=8'h80`, `overflow=1`, `negative=1`, `carry=0`, `zero=0`. This also checks all outputs are 0 out of reset.
- SUB 8'h05−8'h05 → `result=0`, `zero=1`, `carry=1`, `overflow=0`. Then SUB 8'h03−8'h05 → `8'hFE`, `carry=0`, `negative=1`.
- SLL 8'h81 by 3 → `busy` for cycles k+1…k+3, `done` at k+4, `result=8'h08`, `carry=0`. SRA 8'h90 by 4 → `8'hF9`, `carry=0`. SRL by 0 → `done` at k+1, `carry=0`.
- MUL 8'h0F×8'h11 → `done` at k+9, `result=8'hFF`, `carry=0`. MUL 8'h10×8'h10 → `result=0`, `zero=1`, `carry=1`.
- Pulse `start` with a different op during the MUL busy window → ignored, MUL result is unchanged. Opcode 4'hC → `done` at k+1, `result=0`, `illegal=1`. A following MOVE clears `illegal`.
- Assert `reset_n=0` at k+4 of a MUL → `busy`, `done` and all outputs go to 0 immediately. After release, ADD 1+1 completes normally with `result=8'h02`.
